// File: rtl/shift_rot_pkg.sv
// Shared definitions for the shift/rotate pipeline.
// Holds the operation encodings and small helpers that classify an op code.
// Used by: shift_rot_pipe (top) and shift_rot_stage (per-bit stage).
package shift_rot_pkg;

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_ROR = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    // True for the five defined encodings; 101-111 are illegal.
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_SRA: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for the non-rotating ops, which saturate when the amount reaches WIDTH.
    function automatic logic op_is_shift(input logic [2:0] op);
        logic shift;
        case (op)
            OP_SHL, OP_SHR, OP_SRA: shift = 1'b1;
            default:                shift = 1'b0;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/shift_rot_stage.sv
// One stage of the logarithmic shifter pipeline.
// Stage STAGE moves the word by 2**STAGE positions when bit STAGE of the
// effective amount is set, otherwise passes it through, then registers the
// result together with the rest of the payload when en is high.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   global advance enable (all stages move together)
//   in_valid..in_sat     payload coming from the previous stage
//   out_valid..out_sat   registered payload for the next stage
//   out_zero             registered flag: out_data == 0
module shift_rot_stage
    import shift_rot_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGE = 0,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [2:0]       in_op,
    input  logic             in_err,
    input  logic             in_sat,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LOG2W-1:0] out_amt,
    output logic [2:0]       out_op,
    output logic             out_err,
    output logic             out_sat,
    output logic             out_zero
);

    localparam int SH = 2 ** STAGE;

    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] fill_s;
    logic [WIDTH-1:0] data_nxt_s;

    // Candidate word moved by this stage's fixed distance. ROR was turned into
    // an equivalent left rotate at the pipe input, so both rotate left here.
    always_comb begin
        step_s = in_data;
        case (in_op)
            OP_ROL, OP_ROR: step_s = (in_data << SH) | (in_data >> (WIDTH - SH));
            OP_SHL:         step_s = in_data << SH;
            OP_SHR:         step_s = in_data >> SH;
            OP_SRA:         step_s = $signed(in_data) >>> SH;
            default:        step_s = in_data;
        endcase
    end

    // Saturated shifts collapse to the fill pattern; forcing it in every stage
    // is idempotent because the sign bit of an SRA word never changes.
    always_comb begin
        fill_s = {WIDTH{1'b0}};
        if (in_op == OP_SRA) begin
            fill_s = {WIDTH{in_data[WIDTH-1]}};
        end else begin
            fill_s = {WIDTH{1'b0}};
        end
    end

    // Select what this stage hands on: illegal ops pass untouched.
    always_comb begin
        data_nxt_s = in_data;
        if (in_err) begin
            data_nxt_s = in_data;
        end else if (in_sat) begin
            data_nxt_s = fill_s;
        end else if (in_amt[STAGE]) begin
            data_nxt_s = step_s;
        end else begin
            data_nxt_s = in_data;
        end
    end

    // Stage valid bit; bubbles travel as invalid entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
        end
    end

    // Enable-gated payload register, including the zero flag of the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= {WIDTH{1'b0}};
            out_amt  <= {LOG2W{1'b0}};
            out_op   <= 3'b000;
            out_err  <= 1'b0;
            out_sat  <= 1'b0;
            out_zero <= 1'b1;
        end else if (en) begin
            out_data <= data_nxt_s;
            out_amt  <= in_amt;
            out_op   <= in_op;
            out_err  <= in_err;
            out_sat  <= in_sat;
            out_zero <= (data_nxt_s == {WIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/shift_rot_pipe.sv
// Pipelined barrel shifter / rotator with valid-ready handshakes.
// LOG2W stages, one per amount bit; the whole pipe advances on a single
// enable, so a result appears LOG2W cycles after acceptance when unstalled.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake
//   in_data, in_amt, in_op      operand, unsigned amount, op code (shift_rot_pkg)
//   out_valid/out_ready         downstream handshake
//   out_data, out_zero, out_err result, result==0 flag, illegal-op flag
module shift_rot_pipe
    import shift_rot_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    localparam int LOG2W = $clog2(WIDTH);

    // Index 0 is the prepared input; index k+1 is the output of stage k.
    logic [LOG2W:0]                v_s;
    logic [LOG2W:0][WIDTH-1:0]     d_s;
    logic [LOG2W:0][LOG2W-1:0]     a_s;
    logic [LOG2W:0][2:0]           o_s;
    logic [LOG2W:0]                e_s;
    logic [LOG2W:0]                s_s;
    logic [LOG2W-1:0]              z_s;

    logic                          adv_s;
    logic [LOG2W-1:0]              eff_amt_s;
    logic                          sat_s;
    logic                          unused_s;

    // A stage only blocks when the final result is held by downstream.
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    // Prepare the effective amount and saturation flag. ROR by n becomes
    // ROL by (WIDTH - n) mod WIDTH, which is the negated low amount bits.
    always_comb begin
        eff_amt_s = in_amt[LOG2W-1:0];
        sat_s     = 1'b0;
        if (in_op == OP_ROR) begin
            eff_amt_s = {LOG2W{1'b0}} - in_amt[LOG2W-1:0];
        end else begin
            eff_amt_s = in_amt[LOG2W-1:0];
        end
        if (op_is_shift(in_op)) begin
            sat_s = |in_amt[WIDTH-1:LOG2W];
        end else begin
            sat_s = 1'b0;
        end
    end

    assign v_s[0] = in_valid;
    assign d_s[0] = in_data;
    assign a_s[0] = eff_amt_s;
    assign o_s[0] = in_op;
    assign e_s[0] = !op_is_legal(in_op);
    assign s_s[0] = sat_s;

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        shift_rot_stage #(
            .WIDTH (WIDTH),
            .STAGE (k),
            .LOG2W (LOG2W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (adv_s),
            .in_valid  (v_s[k]),
            .in_data   (d_s[k]),
            .in_amt    (a_s[k]),
            .in_op     (o_s[k]),
            .in_err    (e_s[k]),
            .in_sat    (s_s[k]),
            .out_valid (v_s[k+1]),
            .out_data  (d_s[k+1]),
            .out_amt   (a_s[k+1]),
            .out_op    (o_s[k+1]),
            .out_err   (e_s[k+1]),
            .out_sat   (s_s[k+1]),
            .out_zero  (z_s[k])
        );
    end

    assign out_valid = v_s[LOG2W];
    assign out_data  = d_s[LOG2W];
    assign out_err   = e_s[LOG2W];
    assign out_zero  = z_s[LOG2W-1];

    // Payload fields that have no consumer after the last stage.
    assign unused_s = ^{a_s[LOG2W], o_s[LOG2W], s_s[LOG2W], z_s[LOG2W-2:0]};

endmodule
